alu_uart_host_seq: RTL and testbench

- Host-side initiator for the UART ALU command protocol.
- On one start request, it sends the full frame over a UART transmitter: CMD_A, A, CMD_B, B, CMD_OP, OP, CMD_R.
- It then waits for the one-byte result on the UART receiver.
- It sits between a test/control master and a uart_tx/uart_rx pair, and is used for board loopback and self-test against the ALU-side interface.

---
 rtl/alu_uart_pkg.sv | 20 ++
 rtl/alu_uart_host_seq_if.sv | 35 +++
 rtl/alu_uart_host_seq_timeout_counter.sv | 29 ++
 rtl/alu_uart_host_seq.sv | 158 +++++++++++++++
 tb/tb_alu_uart_host_seq.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART ALU command protocol: command codes,
// frame length and host sequencer state encoding.
package alu_uart_pkg;

    localparam logic [7:0] CMD_A  = 8'h01;
    localparam logic [7:0] CMD_B  = 8'h02;
    localparam logic [7:0] CMD_OP = 8'h03;
    localparam logic [7:0] CMD_R  = 8'h04;

    // CMD_A, A, CMD_B, B, CMD_OP, OP, CMD_R
    localparam int FRAME_LEN = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_RES  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_uart_host_seq_if.sv
// Bundle between the control master, the host sequencer and the UART pair.
// Handshakes: o_tx_start is a one-cycle request per byte, o_tx_data is held
// until the transmitter answers with a one-cycle i_tx_done; i_rx_valid,
// o_result_valid and o_timeout are single-cycle strobes with no back-pressure.
interface alu_uart_host_seq_if
    import alu_uart_pkg::*;
#(
    parameter int N = 8
);
    logic         i_start;
    logic [N-1:0] i_A;
    logic [N-1:0] i_B;
    logic [N-1:0] i_op;
    logic [N-1:0] o_tx_data;
    logic         o_tx_start;
    logic         i_tx_done;
    logic [N-1:0] i_data_rx;
    logic         i_rx_valid;
    logic [N-1:0] o_result;
    logic         o_result_valid;
    logic         o_timeout;
    logic         o_busy;

    // Sequencer side
    modport slave (
        input  i_start, i_A, i_B, i_op, i_tx_done, i_data_rx, i_rx_valid,
        output o_tx_data, o_tx_start, o_result, o_result_valid, o_timeout, o_busy
    );

    // Control master / UART model side
    modport master (
        output i_start, i_A, i_B, i_op, i_tx_done, i_data_rx, i_rx_valid,
        input  o_tx_data, o_tx_start, o_result, o_result_valid, o_timeout, o_busy
    );
endinterface

// File: rtl/alu_uart_host_seq_timeout_counter.sv
// Result-wait watchdog: counts enabled cycles from a clear and flags the
// cycle in which the count reaches TIMEOUT_CYC-1.
module timeout_counter #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_cnt;

    assign o_expired = i_enable && (r_cnt == LAST);

    // Count while enabled; saturate at LAST so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/alu_uart_host_seq.sv
// Host-side initiator: sends CMD_A,A,CMD_B,B,CMD_OP,OP,CMD_R over a UART
// transmitter on one start request, then waits for the one-byte result.
// All outputs are registered from the next-state values, so o_tx_start is
// high exactly during the SEND cycle and o_busy tracks state != IDLE.
module alu_uart_host_seq
    import alu_uart_pkg::*;
#(
    parameter int N           = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst,
    alu_uart_host_seq_if.slave bus,
    output state_t             o_dbg_state
);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t       r_state, w_state_nxt;
    logic [2:0]   r_idx, w_idx_nxt;
    logic [N-1:0] r_a, w_a_nxt;
    logic [N-1:0] r_b, w_b_nxt;
    logic [N-1:0] r_op, w_op_nxt;
    logic [N-1:0] r_tx_data, w_tx_data_nxt;
    logic         r_tx_start, w_tx_start_nxt;
    logic [N-1:0] r_result, w_result_nxt;
    logic         r_result_valid, w_result_valid_nxt;
    logic         r_timeout, w_timeout_nxt;
    logic         r_busy, w_busy_nxt;
    logic         w_clear;
    logic         w_enable;
    logic         w_expired;

    function automatic logic [N-1:0] frame_byte(input logic [2:0] idx,
                                                input logic [N-1:0] a,
                                                input logic [N-1:0] b,
                                                input logic [N-1:0] op);
        case (idx)
            3'd0:    return N'(CMD_A);
            3'd1:    return a;
            3'd2:    return N'(CMD_B);
            3'd3:    return b;
            3'd4:    return N'(CMD_OP);
            3'd5:    return op;
            default: return N'(CMD_R);
        endcase
    endfunction

    assign w_enable = (r_state == WAIT_RES);

    timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_expired(w_expired)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_a_nxt            = r_a;
        w_b_nxt            = r_b;
        w_op_nxt           = r_op;
        w_tx_data_nxt      = r_tx_data;
        w_tx_start_nxt     = 1'b0;
        w_result_nxt       = r_result;
        w_result_valid_nxt = 1'b0;
        w_timeout_nxt      = 1'b0;
        w_clear            = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_a_nxt     = bus.i_A;
                    w_b_nxt     = bus.i_B;
                    w_op_nxt    = bus.i_op;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.i_tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_clear     = 1'b1;
                        w_state_nxt = WAIT_RES;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = SEND;
                    end
                end
            end
            WAIT_RES: begin
                // A result arriving on the expiry cycle takes priority.
                if (bus.i_rx_valid) begin
                    w_result_nxt       = bus.i_data_rx;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = IDLE;
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == SEND) begin
            w_tx_start_nxt = 1'b1;
            w_tx_data_nxt  = frame_byte(w_idx_nxt, w_a_nxt, w_b_nxt, w_op_nxt);
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= 3'd0;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_tx_data      <= '0;
            r_tx_start     <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_a            <= w_a_nxt;
            r_b            <= w_b_nxt;
            r_op           <= w_op_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_tx_start     <= w_tx_start_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_timeout      <= w_timeout_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign bus.o_tx_data      = r_tx_data;
    assign bus.o_tx_start     = r_tx_start;
    assign bus.o_result       = r_result;
    assign bus.o_result_valid = r_result_valid;
    assign bus.o_timeout      = r_timeout;
    assign bus.o_busy         = r_busy;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_alu_uart_host_seq.sv
// Bench for alu_uart_host_seq. Two instances share all stimulus: dut0 has a
// long result timeout and carries the scoreboard, dut1 has TIMEOUT_CYC=16
// and is used for the timeout and result/expiry race sequences.
module tb_alu_uart_host_seq;
  import alu_uart_pkg::*;

  localparam int T_BIG   = 200;
  localparam int T_SMALL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start = 1'b0;
  logic [7:0] a_in = 8'h00, b_in = 8'h00, op_in = 8'h00;
  logic       tx_done = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic       rx_valid = 1'b0;

  state_t dbg0, dbg1;

  alu_uart_host_seq_if #(.N(8)) b0 ();
  alu_uart_host_seq_if #(.N(8)) b1 ();

  assign b0.i_start = start;   assign b1.i_start = start;
  assign b0.i_A = a_in;        assign b1.i_A = a_in;
  assign b0.i_B = b_in;        assign b1.i_B = b_in;
  assign b0.i_op = op_in;      assign b1.i_op = op_in;
  assign b0.i_tx_done = tx_done;   assign b1.i_tx_done = tx_done;
  assign b0.i_data_rx = data_rx;   assign b1.i_data_rx = data_rx;
  assign b0.i_rx_valid = rx_valid; assign b1.i_rx_valid = rx_valid;

  alu_uart_host_seq #(.N(8), .TIMEOUT_CYC(T_BIG)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .o_dbg_state(dbg0)
  );
  alu_uart_host_seq #(.N(8), .TIMEOUT_CYC(T_SMALL)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .o_dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_res_q[$];
  int tx_count = 0;
  int done_count = 0;
  int res_seen = 0;
  int down = 0;
  logic prev_tx_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter model (done 10 cycles after each tx_start) and output monitor.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      down = 0;
    end else begin
      if (b0.o_tx_start) begin
        tx_count++;
        down = 10;
        chk("tx_start_width", {31'd0, prev_tx_start}, 32'd0);
        if (exp_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_byte", {24'd0, b0.o_tx_data}, {24'd0, exp_q.pop_front()});
      end else if (down > 0) begin
        down--;
        if (down == 0) begin
          tx_done = 1'b1;
          done_count++;
        end
      end
      if (b0.o_result_valid) begin
        res_seen++;
        chk("busy_after_result", {31'd0, b0.o_busy}, 32'd0);
        if (exp_res_q.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
        else chk("result_byte", {24'd0, b0.o_result}, {24'd0, exp_res_q.pop_front()});
      end
    end
    prev_tx_start = b0.o_tx_start;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b0.o_busy || b1.o_busy) && n < 500) begin
      step();
      n++;
    end
    if (b0.o_busy || b1.o_busy) chk("idle_wait", 32'd1, 32'd0);
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (done_count < target && n < 400) begin
      step();
      n++;
    end
    if (done_count < target) chk("dones_wait", done_count, target);
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_count < target && n < 400) begin
      step();
      n++;
    end
    if (tx_count < target) chk("tx_wait", tx_count, target);
  endtask

  int base_done, base_tx;

  // Push the expected frame, issue start, check first-byte latency.
  task automatic start_frame(input logic [7:0] a_v, input logic [7:0] b_v, input logic [7:0] op_v);
    wait_idle();
    base_done = done_count;
    base_tx = tx_count;
    exp_q.push_back(8'h01); exp_q.push_back(a_v);
    exp_q.push_back(8'h02); exp_q.push_back(b_v);
    exp_q.push_back(8'h03); exp_q.push_back(op_v);
    exp_q.push_back(8'h04);
    @(posedge clk); #1;
    start = 1'b1; a_in = a_v; b_in = b_v; op_in = op_v;
    @(posedge clk); #1;
    start = 1'b0;
    step();
    chk("start_latency_tx_start", {31'd0, b0.o_tx_start}, 32'd1);
    chk("start_latency_busy", {31'd0, b0.o_busy}, 32'd1);
  endtask

  // Wait for the 7th done, return rx_v after dly cycles, wait for capture.
  task automatic finish_frame(input logic [7:0] rx_v, input int dly);
    int r0;
    int n = 0;
    wait_dones(base_done + 7);
    exp_res_q.push_back(rx_v);
    r0 = res_seen;
    repeat (dly) @(posedge clk);
    @(posedge clk); #1;
    rx_valid = 1'b1; data_rx = rx_v;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    while (res_seen == r0 && n < 20) begin
      step();
      n++;
    end
    chk("result_seen", res_seen - r0, 32'd1);
    chk("result_hold", {24'd0, b0.o_result}, {24'd0, rx_v});
  endtask

  typedef struct {
    logic [7:0] a, b, op, rx;
    int         dly;
    logic [7:0] exp_res;
  } vec_t;
  vec_t vecs[5];

  int   to_at;
  logic saw_valid;

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, rx: 8'h08, dly: 50, exp_res: 8'h08};
    vecs[1] = '{a: 8'h00, b: 8'h00, op: 8'h00, rx: 8'h00, dly: 3,  exp_res: 8'h00};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, op: 8'hFF, rx: 8'hFF, dly: 0,  exp_res: 8'hFF};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, op: 8'h01, rx: 8'hC3, dly: 13, exp_res: 8'hC3};
    vecs[4] = '{a: 8'h12, b: 8'h34, op: 8'h56, rx: 8'h9E, dly: 7,  exp_res: 8'h9E};

    // Reset values
    repeat (3) step();
    chk("rst_tx_data", {24'd0, b0.o_tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, b0.o_tx_start}, 32'd0);
    chk("rst_result", {24'd0, b0.o_result}, 32'd0);
    chk("rst_result_valid", {31'd0, b0.o_result_valid}, 32'd0);
    chk("rst_timeout", {31'd0, b0.o_timeout}, 32'd0);
    chk("rst_busy", {31'd0, b0.o_busy}, 32'd0);
    chk("rst_state", {30'd0, dbg0}, {30'd0, IDLE});
    rst = 1'b0;
    repeat (2) step();

    // Table-driven frames (vector 0 is the basic frame)
    for (int i = 0; i < 5; i++) begin
      start_frame(vecs[i].a, vecs[i].b, vecs[i].op);
      finish_frame(vecs[i].rx, vecs[i].dly);
      step();
      chk("vec_result", {24'd0, b0.o_result}, {24'd0, vecs[i].exp_res});
      chk("vec_busy_low", {31'd0, b0.o_busy}, 32'd0);
    end

    // Operand latch: A changes shortly after start; second byte stays 05
    start_frame(8'h05, 8'h03, 8'h20);
    @(posedge clk); #1;
    a_in = 8'hFF;
    finish_frame(8'h08, 5);
    chk("latch_dut1_result", {24'd0, b1.o_result}, 32'h08);

    // Timeout on dut1: pulse 17 negedges after the last done's negedge
    start_frame(8'h21, 8'h43, 8'h65);
    wait_dones(base_done + 7);
    to_at = 0;
    saw_valid = 1'b0;
    for (int n = 1; n <= 40 && to_at == 0; n++) begin
      step();
      if (b1.o_result_valid) saw_valid = 1'b1;
      if (b1.o_timeout) to_at = n;
    end
    chk("timeout_cycle", to_at, 32'd17);
    chk("timeout_no_valid", {31'd0, saw_valid}, 32'd0);
    chk("timeout_result_kept", {24'd0, b1.o_result}, 32'h08);
    step();
    chk("timeout_pulse_width", {31'd0, b1.o_timeout}, 32'd0);
    chk("timeout_idle", {31'd0, b1.o_busy}, 32'd0);

    // Ignored inputs: start during byte 3, stray rx during WAIT_DONE
    start_frame(8'h31, 8'h32, 8'h33);
    wait_tx(base_tx + 3);
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'h99; rx_valid = 1'b1; data_rx = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    finish_frame(8'h11, 4);
    repeat (30) step();
    chk("ignored_tx_count", tx_count - base_tx, 32'd7);
    chk("ignored_result", {24'd0, b0.o_result}, 32'h11);

    // Race on dut1: rx_valid in the expiry cycle, result wins
    start_frame(8'h44, 8'h55, 8'h66);
    wait_dones(base_done + 7);
    exp_res_q.push_back(8'h5A);
    repeat (16) @(posedge clk);
    #1;
    rx_valid = 1'b1; data_rx = 8'h5A;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    step();
    chk("race_valid", {31'd0, b1.o_result_valid}, 32'd1);
    chk("race_timeout", {31'd0, b1.o_timeout}, 32'd0);
    chk("race_result", {24'd0, b1.o_result}, 32'h5A);

    // Reset mid-frame after byte 4's tx_start
    start_frame(8'h05, 8'h03, 8'h20);
    wait_tx(base_tx + 4);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_tx_data", {24'd0, b0.o_tx_data}, 32'd0);
    chk("mrst_tx_start", {31'd0, b0.o_tx_start}, 32'd0);
    chk("mrst_result", {24'd0, b0.o_result}, 32'd0);
    chk("mrst_result_valid", {31'd0, b0.o_result_valid}, 32'd0);
    chk("mrst_timeout", {31'd0, b0.o_timeout}, 32'd0);
    chk("mrst_busy", {31'd0, b0.o_busy}, 32'd0);
    chk("mrst_pending_bytes", exp_q.size(), 32'd3);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (30) step();
    chk("mrst_no_tx", tx_count - base_tx, 32'd4);
    start_frame(8'h05, 8'h03, 8'h20);
    finish_frame(8'h77, 2);

    wait_idle();
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("exp_res_q_empty", exp_res_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
